jedro_1_ifu: RTL and testbench

- Instruction fetch unit of the jedro_1 core; sits directly upstream of the decoder.
- Drives the read-only instruction memory port, which has 1-cycle read latency, and keeps the program counter.
- Buffers fetched words in a small prefetch FIFO.
- Presents instruction/address pairs to the decoder over a valid/ready handshake.
- Accepts jump/branch redirects and flushes wrong-path instructions.

---
 rtl/jedro_1_ifu.sv | 109 ++++++++++
 tb/tb_jedro_1_ifu.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jedro_1_ifu.sv
// jedro_1 instruction fetch unit: keeps the PC, issues 1-cycle-latency imem reads,
// buffers responses in a prefetch FIFO and hands {instr, addr} to the decoder.
//
// state | meaning
// RUN   | normal issue, responses pushed into the FIFO
// FLUSH | cycle after a redirect with a read outstanding; that response is dropped
module jedro_1_ifu #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  imem_en_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    input  logic                  jmp_valid_i,
    input  logic [ADDR_WIDTH-1:0] jmp_addr_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] instr_addr_o,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic                  inflight_q;
    logic [PW-1:0]         rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         occupancy;
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
    logic                  issue, push, pop, kill, not_empty;
    logic [1:0]            unused_jmp_low;

    assign unused_jmp_low = jmp_addr_i[1:0];

    // count+inflight bounded so a response always has a free slot
    assign occupancy = count_q + {{(CW-1){1'b0}}, inflight_q};
    assign issue     = !rst_i && !jmp_valid_i && (occupancy < CW'(FIFO_DEPTH));
    assign kill      = (state_q == FLUSH);
    assign push      = inflight_q && !kill && !jmp_valid_i;
    assign not_empty = (count_q != '0);
    assign pop       = instr_valid_o && instr_ready_i;

    assign imem_en_o     = issue;
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = not_empty && !jmp_valid_i;
    assign instr_o       = not_empty ? fifo_data[rd_ptr_q] : '0;
    assign instr_addr_o  = not_empty ? fifo_addr[rd_ptr_q] : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     state_d = (jmp_valid_i && (inflight_q || issue)) ? FLUSH : RUN;
            FLUSH:   state_d = (jmp_valid_i && (inflight_q || issue)) ? FLUSH : RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            pc_q       <= BOOT_ADDR;
            req_addr_q <= '0;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            if (issue) begin
                pc_q       <= pc_q + ADDR_WIDTH'(4);
                req_addr_q <= pc_q;
            end
            if (jmp_valid_i) begin
                pc_q     <= {jmp_addr_i[ADDR_WIDTH-1:2], 2'b00};
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
                case ({push, pop})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Storage needs no reset: entries are only visible while count_q covers them
    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            fifo_data[wr_ptr_q] <= imem_rdata_i;
            fifo_addr[wr_ptr_q] <= req_addr_q;
        end
    end

endmodule

// File: tb/tb_jedro_1_ifu.sv
// Self-checking bench for jedro_1_ifu: directed scenarios plus a randomized run
// scored against an in-order instruction-stream model.
module tb_jedro_1_ifu;

    logic        clk = 1'b0;
    logic        rst, jmp_valid, instr_ready;
    logic [31:0] jmp_addr, imem_rdata;
    logic        imem_en, instr_valid;
    logic [31:0] imem_addr, instr, instr_addr;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] pa[$];
    logic [31:0] pd[$];
    logic [31:0] ia[$];

    jedro_1_ifu dut (
        .clk_i(clk), .rst_i(rst),
        .imem_en_o(imem_en), .imem_addr_o(imem_addr), .imem_rdata_i(imem_rdata),
        .jmp_valid_i(jmp_valid), .jmp_addr_i(jmp_addr),
        .instr_o(instr), .instr_addr_o(instr_addr),
        .instr_valid_o(instr_valid), .instr_ready_i(instr_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (32'h9E37_79B9 * (a >> 2)) + 32'h1234_5678;
    endfunction

    // 1-cycle latency read-only memory
    always @(posedge clk) imem_rdata <= imem_en ? rom(imem_addr) : 32'hDEAD_BEEF;

    task automatic tick();
        #1;
        if (instr_valid && instr_ready) begin
            pa.push_back(instr_addr);
            pd.push_back(instr);
        end
        if (imem_en) ia.push_back(imem_addr);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic rdy);
        rst = 1'b1; jmp_valid = 1'b0; jmp_addr = '0; instr_ready = rdy;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        pa.delete(); pd.delete(); ia.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; jmp_valid = 1'b0; jmp_addr = '0; instr_ready = 1'b1;
        #1;
        n_cmp++; if (imem_en !== 1'b0) begin n_err++; $display("FAIL reset_en_in_rst: got %b exp 0", imem_en); end
        @(negedge clk); #1;
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b exp 0", instr_valid); end
        n_cmp++; if (instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h exp 0", instr); end
        n_cmp++; if (instr_addr !== 32'h0) begin n_err++; $display("FAIL reset_instr_addr: got %h exp 0", instr_addr); end
        @(negedge clk);
        rst = 1'b0;
        pa.delete(); pd.delete(); ia.delete();
        #1;
        n_cmp++; if (imem_en !== 1'b1 || imem_addr !== 32'h0)
            begin n_err++; $display("FAIL first_fetch: got en=%b addr=%h exp en=1 addr=0", imem_en, imem_addr); end
        tick();
        #1;
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL valid_early: got %b exp 0", instr_valid); end
        tick();
        #1;
        n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL valid_latency: got %b exp 1", instr_valid); end
        tick(); tick(); tick();
        n_cmp++; if (pa.size() != 3) begin n_err++; $display("FAIL stream_count: got %0d exp 3", pa.size()); end
        for (int i = 0; i < 3 && i < pa.size(); i++) begin
            n_cmp++;
            if (pa[i] !== 32'(4*i) || pd[i] !== rom(32'(4*i))) begin
                n_err++; $display("FAIL stream_pair%0d: got (%h,%h) exp (%h,%h)", i, pd[i], pa[i], rom(32'(4*i)), 4*i);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset(1'b0);
        for (int c = 0; c < 10; c++) tick();
        n_cmp++; if (ia.size() != 4) begin n_err++; $display("FAIL bp_fetch_count: got %0d exp 4", ia.size()); end
        #1;
        n_cmp++; if (imem_en !== 1'b0) begin n_err++; $display("FAIL bp_en_stop: got %b exp 0", imem_en); end
        n_cmp++; if (instr_valid !== 1'b1 || instr !== rom(32'h0))
            begin n_err++; $display("FAIL bp_hold: got v=%b %h exp v=1 %h", instr_valid, instr, rom(32'h0)); end
        instr_ready = 1'b1;
        for (int c = 0; c < 30 && pa.size() < 8; c++) tick();
        n_cmp++; if (pa.size() < 8) begin n_err++; $display("FAIL bp_drain_timeout: got %0d pops exp 8", pa.size()); end
        for (int i = 0; i < 8 && i < pa.size(); i++) begin
            n_cmp++;
            if (pa[i] !== 32'(4*i) || pd[i] !== rom(32'(4*i))) begin
                n_err++; $display("FAIL bp_pop%0d: got (%h,%h) exp (%h,%h)", i, pd[i], pa[i], rom(32'(4*i)), 4*i);
            end
        end
        for (int i = 0; i < ia.size(); i++) begin
            n_cmp++;
            if (ia[i] !== 32'(4*i)) begin n_err++; $display("FAIL bp_issue%0d: got %h exp %h", i, ia[i], 4*i); end
        end
    endtask

    task automatic test_jump_full();
        do_reset(1'b0);
        for (int c = 0; c < 4; c++) tick();
        jmp_valid = 1'b1; jmp_addr = 32'h40;
        #1;
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL jf_valid_in_jump: got %b exp 0", instr_valid); end
        tick();
        jmp_valid = 1'b0;
        pa.delete(); pd.delete();
        #1;
        n_cmp++; if (imem_en !== 1'b1 || imem_addr !== 32'h40)
            begin n_err++; $display("FAIL jf_target_fetch: got en=%b %h exp en=1 40", imem_en, imem_addr); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL jf_valid_j1: got %b exp 0", instr_valid); end
        tick();
        #1;
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL jf_valid_j2: got %b exp 0", instr_valid); end
        tick();
        #1;
        n_cmp++; if (instr_valid !== 1'b1 || instr_addr !== 32'h40 || instr !== rom(32'h40))
            begin n_err++; $display("FAIL jf_first: got v=%b (%h,%h) exp v=1 (%h,40)", instr_valid, instr, instr_addr, rom(32'h40)); end
        instr_ready = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        n_cmp++; if (pa.size() < 8) begin n_err++; $display("FAIL jf_pop_count: got %0d exp >=8", pa.size()); end
        for (int i = 0; i < pa.size(); i++) begin
            n_cmp++;
            if (pa[i] !== 32'h40 + 32'(4*i) || pd[i] !== rom(32'h40 + 32'(4*i))) begin
                n_err++; $display("FAIL jf_pop%0d: got (%h,%h) exp addr %h", i, pd[i], pa[i], 32'h40 + 32'(4*i));
            end
        end
    endtask

    task automatic test_jump_unaligned();
        do_reset(1'b1);
        for (int c = 0; c < 5; c++) tick();
        jmp_valid = 1'b1; jmp_addr = 32'h43;
        tick();
        jmp_valid = 1'b0;
        pa.delete(); pd.delete();
        #1;
        n_cmp++; if (imem_en !== 1'b1 || imem_addr !== 32'h40)
            begin n_err++; $display("FAIL ju_fetch: got en=%b %h exp en=1 40", imem_en, imem_addr); end
        for (int c = 0; c < 8; c++) tick();
        n_cmp++; if (pa.size() == 0 || pa[0] !== 32'h40 || pd[0] !== rom(32'h40))
            begin n_err++; $display("FAIL ju_first_pop: got %0d pops first %h exp 40", pa.size(), (pa.size() > 0) ? pa[0] : 32'hx); end
    endtask

    task automatic test_double_jump();
        do_reset(1'b1);
        for (int c = 0; c < 5; c++) tick();
        jmp_valid = 1'b1; jmp_addr = 32'h80;
        tick();
        jmp_addr = 32'hC0;
        tick();
        jmp_valid = 1'b0;
        pa.delete(); pd.delete();
        for (int c = 0; c < 10; c++) tick();
        n_cmp++; if (pa.size() < 5) begin n_err++; $display("FAIL dj_pop_count: got %0d exp >=5", pa.size()); end
        for (int i = 0; i < pa.size(); i++) begin
            n_cmp++;
            if (pa[i] !== 32'hC0 + 32'(4*i) || pd[i] !== rom(32'hC0 + 32'(4*i))) begin
                n_err++; $display("FAIL dj_pop%0d: got (%h,%h) exp addr %h", i, pd[i], pa[i], 32'hC0 + 32'(4*i));
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        for (int c = 0; c < 4; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pa.delete(); pd.delete();
        #1;
        n_cmp++; if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_addr !== 32'h0)
            begin n_err++; $display("FAIL rm_outputs: got v=%b (%h,%h) exp all 0", instr_valid, instr, instr_addr); end
        n_cmp++; if (imem_en !== 1'b1 || imem_addr !== 32'h0)
            begin n_err++; $display("FAIL rm_refetch: got en=%b %h exp en=1 0", imem_en, imem_addr); end
        instr_ready = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        n_cmp++; if (pa.size() < 3) begin n_err++; $display("FAIL rm_pop_count: got %0d exp >=3", pa.size()); end
        for (int i = 0; i < 3 && i < pa.size(); i++) begin
            n_cmp++;
            if (pa[i] !== 32'(4*i) || pd[i] !== rom(32'(4*i))) begin
                n_err++; $display("FAIL rm_pop%0d: got (%h,%h) exp (%h,%h)", i, pd[i], pa[i], rom(32'(4*i)), 4*i);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_addr, prev_instr, prev_addr;
        logic        prev_stall;
        int          occ, npops;
        do_reset(1'b1);
        exp_addr = 32'h0; occ = 0; npops = 0; prev_stall = 1'b0;
        prev_instr = '0; prev_addr = '0;
        for (int c = 0; c < 800; c++) begin
            instr_ready = ($urandom_range(0, 9) < 7);
            jmp_valid   = ($urandom_range(0, 19) == 0);
            jmp_addr    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F))
                                                      : ($urandom & 32'h0000_0FFF);
            #1;
            if (prev_stall && !jmp_valid) begin
                n_cmp++;
                if (instr_valid !== 1'b1 || instr !== prev_instr || instr_addr !== prev_addr) begin
                    n_err++; $display("FAIL rnd_hold c%0d: got v=%b (%h,%h) exp (%h,%h)", c, instr_valid, instr, instr_addr, prev_instr, prev_addr);
                end
            end
            if (jmp_valid) begin
                n_cmp++;
                if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rnd_jmp_valid c%0d: got %b exp 0", c, instr_valid); end
            end
            if (instr_valid && instr_ready) begin
                n_cmp++;
                if (instr_addr !== exp_addr || instr !== rom(exp_addr)) begin
                    n_err++; $display("FAIL rnd_pop c%0d: got (%h,%h) exp (%h,%h)", c, instr, instr_addr, rom(exp_addr), exp_addr);
                end
                exp_addr = exp_addr + 32'd4;
                npops++;
            end
            if (jmp_valid) begin
                exp_addr = jmp_addr & 32'hFFFF_FFFC;
                occ = 0;
            end else begin
                occ = occ + int'(imem_en) - int'(instr_valid && instr_ready);
            end
            n_cmp++;
            if (occ > 4 || occ < 0) begin n_err++; $display("FAIL rnd_overflow c%0d: got occupancy %0d exp 0..4", c, occ); end
            prev_stall = instr_valid && !instr_ready && !jmp_valid;
            prev_instr = instr;
            prev_addr  = instr_addr;
            @(negedge clk);
        end
        jmp_valid = 1'b0;
        n_cmp++; if (npops < 100) begin n_err++; $display("FAIL rnd_throughput: got %0d pops exp >=100", npops); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; jmp_valid = 1'b0; jmp_addr = '0; instr_ready = 1'b1;
        test_reset();
        test_backpressure();
        test_jump_full();
        test_jump_unaligned();
        test_double_jump();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
